math_pipelined_arbiter: RTL and testbench

- Round-robin controller that shares one multi-cycle chunked add/sub unit among NUM_REQ requesters.
- Accepts one operation at a time through a valid/ready handshake, drives the unit's clock-enable and operand buses, and holds the operands for LATENCY cycles.
- Captures the sum or difference and returns it, tagged with the requester index, on a single response port.
- Sits between client logic (counters, accumulators) and the shared math unit.

---
 rtl/math_pipelined_arbiter.sv | 135 +++++++++++++
 tb/tb_math_pipelined_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_pipelined_arbiter.sv
// Round-robin front end that shares one multi-cycle add/sub unit among NUM_REQ requesters.
// One operation in flight at a time; the response is held until it is accepted.
module math_pipelined_arbiter #(
  parameter int WIDTH    = 4,
  parameter int LATENCY  = 4,
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       alu_ce,
  output logic [WIDTH-1:0]           alu_i1,
  output logic [WIDTH-1:0]           alu_i2,
  input  logic [WIDTH-1:0]           alu_sum,
  input  logic [WIDTH-1:0]           alu_sub,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [WIDTH-1:0]           rsp_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] next_ptr;
  logic                found;
  logic                sel_op;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic [CW-1:0]       cnt;
  logic                lat_op;
  logic [ID_WIDTH-1:0] lat_id;
  logic [WIDTH-1:0]    lat_a;
  logic [WIDTH-1:0]    lat_b;

  // Winner is the valid requester with the smallest circular distance from rr_ptr.
  always_comb begin
    int best;
    best   = NUM_REQ;
    grant  = '0;
    sel_op = 1'b0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int d;
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NUM_REQ;
      if (req_valid[i] && d < best) begin
        best   = d;
        grant  = ID_WIDTH'(i);
        sel_op = req_op[i];
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
    found = |req_valid;
  end

  always_comb begin
    if (int'(grant) == NUM_REQ - 1) next_ptr = '0;
    else                            next_ptr = grant + ID_WIDTH'(1);
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = !rst && (state == S_IDLE) && found && (grant == ID_WIDTH'(i));
  end

  assign alu_ce = (state == S_ISSUE);
  assign alu_i1 = lat_a;
  assign alu_i2 = lat_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      lat_op    <= 1'b0;
      lat_id    <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            lat_op <= sel_op;
            lat_id <= grant;
            lat_a  <= sel_a;
            lat_b  <= sel_b;
            rr_ptr <= next_ptr;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CW'(LATENCY - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= lat_op ? alu_sub : alu_sum;
            rsp_id    <= lat_id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          // Result registers are left holding the last value after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_math_pipelined_arbiter.sv
// Bench for math_pipelined_arbiter: directed table, hand sequences and a random run
// checked every cycle against a transaction-level model of the arbiter.
module tb_math_pipelined_arbiter;

  localparam int W  = 4;
  localparam int L  = 4;
  localparam int N  = 2;
  localparam int AW = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_op;
  logic [AW-1:0]   req_a, req_b;
  logic            alu_ce;
  logic [W-1:0]    alu_i1, alu_i2, alu_sum, alu_sub;
  logic            rsp_valid, rsp_ready;
  logic [0:0]      rsp_id;
  logic [W-1:0]    rsp_data;

  math_pipelined_arbiter #(.WIDTH(W), .LATENCY(L), .NUM_REQ(N), .ID_WIDTH(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .alu_ce(alu_ce), .alu_i1(alu_i1), .alu_i2(alu_i2),
    .alu_sum(alu_sum), .alu_sub(alu_sub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Math unit: result appears exactly L cycles after the ce cycle, junk otherwise.
  logic [W-1:0] ps [L];
  logic [W-1:0] pd [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      ps[i] <= ps[i-1];
      pd[i] <= pd[i-1];
    end
    ps[0] <= alu_ce ? alu_i1 + alu_i2 : 4'h5;
    pd[0] <= alu_ce ? alu_i1 - alu_i2 : 4'hA;
  end
  assign alu_sum = ps[L-1];
  assign alu_sub = pd[L-1];

  // Second instance with three requesters and a combinational math unit.
  logic [2:0]   v3, r3, op3;
  logic [11:0]  a3, b3;
  logic         ce3, rv3, rr3;
  logic [W-1:0] i13, i23, s3, d3, data3;
  logic [1:0]   id3;
  assign s3 = i13 + i23;
  assign d3 = i13 - i23;

  math_pipelined_arbiter #(.WIDTH(W), .LATENCY(L), .NUM_REQ(3), .ID_WIDTH(2)) u3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3), .req_op(op3),
    .req_a(a3), .req_b(b3), .alu_ce(ce3), .alu_i1(i13), .alu_i2(i23),
    .alu_sum(s3), .alu_sub(d3), .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_id(id3), .rsp_data(data3)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  // Reference model: pointer, busy flag and cycles elapsed since accept.
  int m_ptr, m_age, m_id, m_a, m_b, m_res;
  bit m_busy;
  int           gq_cyc[$];
  logic [N-1:0] gq_vec[$];

  typedef struct {
    int          id;
    bit          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int          hold;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_tot++;
    $display("FAIL %s @cycle %0d: expected DUT event did not occur within bound", nm, cyc);
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = 1'b0;
    m_age  = 0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_req_ready"}, 32'(req_ready), 0);
    chk({p, "_alu_ce"},    32'(alu_ce),    0);
    chk({p, "_alu_i1"},    32'(alu_i1),    0);
    chk({p, "_alu_i2"},    32'(alu_i2),    0);
    chk({p, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({p, "_rsp_id"},    32'(rsp_id),    0);
    chk({p, "_rsp_data"},  32'(rsp_data),  0);
  endtask

  // Called at the falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int g;
    bit exp_rv;
    #1;
    if (req_ready != '0) begin
      gq_cyc.push_back(cyc);
      gq_vec.push_back(req_ready);
    end
    exp_rdy = '0;
    g = -1;
    if (!m_busy)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = m_busy && (m_age >= L + 2);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("alu_ce", 32'(alu_ce), 32'(m_busy && m_age == 1));
    if (m_busy) begin
      chk("alu_i1", 32'(alu_i1), 32'(m_a));
      chk("alu_i2", 32'(alu_i2), 32'(m_b));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id",   32'(rsp_id),   32'(m_id));
      chk("rsp_data", 32'(rsp_data), 32'(m_res));
    end
    if (g >= 0) begin
      m_busy = 1'b1;
      m_age  = 0;
      m_id   = g;
      m_a    = int'(req_a[g*W +: W]);
      m_b    = int'(req_b[g*W +: W]);
      m_res  = req_op[g] ? (m_a - m_b + 16) % 16 : (m_a + m_b) % 16;
      m_ptr  = (g + 1) % N;
    end else if (exp_rv && rsp_ready) begin
      m_busy = 1'b0;
    end
    if (m_busy) m_age++;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while (m_busy && n < 4 * L) begin step(); n++; end
    if (m_busy) timeout("drain");
  endtask

  task automatic run_op(input vec_t v, input int t);
    int n;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_valid[v.id] = 1'b1;
    req_op[v.id] = v.op;
    req_a[v.id*W +: W] = v.a;
    req_b[v.id*W +: W] = v.b;
    n = 0;
    while (!m_busy && n < 10) begin step(); n++; end
    if (!m_busy) begin
      timeout($sformatf("tbl%0d_accept", t));
      req_valid = '0;
      return;
    end
    // Everyone now asks and operands churn; none of it may reach the in-flight op.
    req_valid = '1;
    req_op    = N'($urandom);
    req_a     = AW'($urandom);
    req_b     = AW'($urandom);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 3 * L) begin step(); n++; end
    if (rsp_valid !== 1'b1) begin
      timeout($sformatf("tbl%0d_rsp", t));
    end else begin
      repeat (v.hold) step();
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("tbl%0d_data", t), 32'(rsp_data), 32'(v.exp));
      chk($sformatf("tbl%0d_id", t),   32'(rsp_id),   32'(v.id));
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0] = '{0, 1'b0, 4'd7,  4'd9,  0, 4'd0};
    tbl[1] = '{1, 1'b1, 4'd3,  4'd5,  5, 4'd14};
    tbl[2] = '{0, 1'b0, 4'd15, 4'd1,  0, 4'd0};
    tbl[3] = '{1, 1'b1, 4'd0,  4'd1,  2, 4'd15};
    tbl[4] = '{0, 1'b0, 4'd2,  4'd1,  3, 4'd3};
    tbl[5] = '{1, 1'b1, 4'd9,  4'd4,  1, 4'd5};
    tbl[6] = '{0, 1'b1, 4'd4,  4'd12, 0, 4'd8};

    rst = 1'b1;
    req_valid = '1; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    v3 = '0; op3 = '0; a3 = '0; b3 = '0; rr3 = 1'b0;
    @(negedge clk);
    #1;
    chk_zero("reset");
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int t = 0; t < 7; t++) run_op(tbl[t], t);
    drain();

    // Round robin with both requesters always asking.
    do_reset();
    gq_cyc.delete();
    gq_vec.delete();
    req_valid = '1;
    rsp_ready = 1'b1;
    req_op = N'($urandom);
    req_a  = AW'($urandom);
    req_b  = AW'($urandom);
    repeat (5 * (L + 3)) step();
    chk("rr_grants_seen", 32'(gq_vec.size() >= 4), 1);
    if (gq_vec.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr_grant%0d", i), 32'(gq_vec[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(gq_cyc[i] - gq_cyc[i-1]), L + 3);
      end
    drain();

    // Reset while requester 1's operation is in WAIT.
    do_reset();
    req_valid = 2'b10;
    req_op = 2'b10; req_a = 8'h30; req_b = 8'h50;
    rsp_ready = 1'b0;
    n = 0;
    while (!m_busy && n < 10) begin step(); n++; end
    if (!m_busy) timeout("midrst_accept");
    req_valid = '1;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (L + 4) step();
    req_valid = '1;
    #1;
    chk("grant_after_rst", 32'(req_ready), 1);
    step();
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req_valid = N'($urandom);
      req_op    = N'($urandom);
      req_a     = AW'($urandom);
      req_b     = AW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Three requesters: lone requester 2 wins, pointer wraps to 0.
    v3 = 3'b100; op3 = 3'b000;
    a3 = 12'h500; b3 = 12'h600; rr3 = 1'b1;
    #1;
    chk("n3_ready", 32'(r3), 32'h4);
    @(posedge clk);
    @(negedge clk);
    v3 = '0;
    n = 0;
    while (rv3 !== 1'b1 && n < 3 * L) begin @(posedge clk); @(negedge clk); n++; end
    if (rv3 !== 1'b1) timeout("n3_rsp");
    else begin
      chk("n3_id",   32'(id3),   2);
      chk("n3_data", 32'(data3), 11);
    end
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b110;
    #1;
    chk("n3_wrap", 32'(r3), 32'h2);
    @(posedge clk);
    @(negedge clk);
    v3 = '0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
